tb_mem_bus_ctrl: RTL and testbench
==================================

# tb_mem_bus_ctrl

Two-port memory bus controller between the CPU core and the bench memory model. It arbitrates between the CPU instruction-fetch port and the data load/store port, and drives one request at a time onto the memory's `req_rdwr`/`data_ready` handshake. When the access completes, it returns the read data to the requesting port with a one-cycle valid pulse.

## Interface
- `MIN_LAT`, default 2: memory cycles after issue before `mem_data_ready` is trusted.
- `TIMEOUT_CYCLES`, default 15: watchdog limit. Used only with `MEM_BUS_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; clock clk.
- `if_req`  in  1  fetch request. Held with `if_addr` until `if_valid`.
- `if_addr`  in  16  fetch address. Fetches are always 16-bit reads.
- `if_rdata`  out  16  fetch data.
- `if_valid`  out  1  fetch-complete pulse.
- `d_req`  in  1  data request. Held with its attributes until `d_valid`.
- `d_addr`  in  16  data address.
- `d_we`  in  1  1 = write.
- `d_sz`  in  1  access size, `cpu_data_acc_sz_8` or `cpu_data_acc_sz_16`.
- `d_wdata`  in  16  write data. An 8-bit write uses `[7:0]`.
- `d_rdata`  out  16  read data. An 8-bit read is zero-extended.
- `d_valid`  out  1  data-complete pulse.
- `mem_req_rdwr`  out  1  memory request.
- `mem_addr`  out  16  memory address.
- `mem_acc_sz`  out  1  memory access size.
- `mem_we_8`, `mem_we_16`  out  1 each  write enables.
- `mem_wdata_8`  out  8  8-bit write data to memory.
- `mem_wdata_16`  out  16  16-bit write data to memory.
- `mem_rdata_8`  in  8  8-bit read data from memory.
- `mem_rdata_16`  in  16  16-bit read data from memory.
- `mem_data_ready`  in  1  memory completion.
- `busy`  out  1  high in every state except IDLE.
- `bus_err`  out  1  sticky timeout flag. Tied 0 without the macro.

## Operation
- States and transitions:
  - IDLE: stay while no request. Otherwise latch the winner into the internal `xact` register, go to ISSUE.
  - ISSUE: one cycle. Go to WAIT with the wait counter at 0.
  - WAIT: increment the counter each cycle. When counter ≥ `MIN_LAT` and `mem_data_ready`=1, go to DONE.
  - DONE: one cycle. Pulse the owner's valid signal, go to IDLE.
- Arbitration: data port wins when both requests are high in IDLE. The fetch port is starved only while `d_req` stays high.
- Latching: `xact` captures port, addr, we, sz, and wdata in IDLE. Input changes after latch are ignored.
- Memory side:
  - `mem_req_rdwr` = 1 in ISSUE and WAIT.
  - `mem_addr`, `mem_acc_sz`, and both `mem_wdata_*` come from `xact` and stay stable from ISSUE through DONE.
  - `mem_we_8` = we && sz==8, and `mem_we_16` = we && sz==16, asserted only in ISSUE and WAIT.
- Read capture: on the WAIT→DONE transition, select `mem_rdata_8` (zero-extended) or `mem_rdata_16` by size, and register it into the owner's rdata.
- Completion values: for a write, rdata is left unchanged and valid still pulses. Non-owner rdata always holds its value.
- `mem_data_ready` is ignored outside WAIT. A stale high from the previous transaction must not complete a new one.
- Back-to-back: a requester still high in DONE is not re-served until IDLE. Minimum spacing between issues is MIN_LAT+3 cycles.

## Timing
- Reset:
  - Synchronous. Forces IDLE, counter 0, and clears `bus_err`.
  - Drives all outputs low: valids, `mem_req_rdwr`, `mem_we_*`, `busy`.
  - Clears rdata registers and `mem_addr`/wdata outputs to 0.
  - Mid-transaction reset abandons the access. No valid pulse follows.
- Latency: request seen in IDLE at cycle 0 → ISSUE at 1 → WAIT at 2.
- With a memory asserting ready 2 cycles after issue: DONE at cycle 4, so valid is high in cycle 4 and data is readable the same cycle.
- All outputs are registered or decoded from the state register. Nothing is combinational from inputs.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - If WAIT lasts `TIMEOUT_CYCLES` cycles without ready: set `bus_err` (sticky until reset) and go to DONE.
  - Valid pulses with rdata forced to 16'hFFFF.
- Undefined: WAIT waits indefinitely, `bus_err` is constant 0, and no timeout counter logic exists.

## Structure
- Shared in `pkg_cpu`:
  - the `cpu_data_acc_sz_8`/`_16` constants;
  - a state enum `mem_bus_state_t` (IDLE, ISSUE, WAIT, DONE);
  - a packed struct `mem_xact_t` (port, addr, we, sz, wdata).
- One sub-module is natural: `mem_bus_arbiter`, a combinational fixed-priority grant plus a registered owner bit. Everything else stays in one module.

## Test plan
- Fetch read: `if_req`, `if_addr`=16'h0004 with memory holding bytes 12,34 at 4,5 → `if_valid` at cycle 4, `if_rdata`=16'h1234 (assuming `make_mem_pair` places the byte at addr in the high half; verify against `cpu_extras_defines.svinc`).
- 8-bit data read of 16'h7FFC holding 8'hAB → `d_valid`, `d_rdata`=16'h00AB, `mem_we_*` never high.
- 16-bit write of 16'hBEEF to 16'h0100 → `mem_we_16` high in ISSUE–WAIT only, `d_valid` pulses, `d_rdata` unchanged.
- Simultaneous `if_req` and `d_req` → data is served first. Fetch issues in the cycle after data DONE+IDLE. Each valid is exactly one cycle.
- Stale ready: `mem_data_ready` held 1 entering ISSUE → no completion before WAIT counter reaches `MIN_LAT`.
- Reset asserted in WAIT → next cycle: IDLE, all outputs 0, no valid. With `MEM_BUS_TIMEOUT_EN` and memory never ready → `bus_err`=1 after 15 WAIT cycles, `d_rdata`=16'hFFFF.

Source files
------------

// File: rtl/tb_mem_bus_ctrl_pkg.sv
// Shared CPU-side definitions for the memory bus controller: access-size
// constants, port identifiers, controller state encoding and the latched
// transaction record.
package pkg_cpu;

  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } mem_port_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_bus_state_t;

  typedef struct packed {
    mem_port_t   port;
    logic [15:0] addr;
    logic        we;
    logic        sz;
    logic [15:0] wdata;
  } mem_xact_t;

  // Pick the memory read lane by access size; byte reads are zero-extended.
  function automatic logic [15:0] sel_rdata(input logic        sz,
                                            input logic [7:0]  r8,
                                            input logic [15:0] r16);
    logic [15:0] r;
    r = (sz == cpu_data_acc_sz_8) ? {8'h00, r8} : r16;
    return r;
  endfunction

endpackage

// File: rtl/tb_mem_bus_ctrl_arbiter.sv
// Fixed-priority arbiter for the memory bus controller. The data port always
// wins over instruction fetch; the winner is remembered as the transaction
// owner when the controller latches a request.
module mem_bus_arbiter
  import pkg_cpu::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      if_req,
  input  logic      d_req,
  input  logic      load,
  output mem_port_t gnt,
  output logic      gnt_any,
  output mem_port_t owner
);

  mem_port_t owner_q;
  mem_port_t owner_d;

  // Combinational grant and owner update.
  always_comb begin
    gnt     = d_req ? PORT_D : PORT_IF;
    gnt_any = d_req | if_req;
    owner_d = load ? gnt : owner_q;
  end

  // Owner register.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= PORT_IF;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner = owner_q;

endmodule

// File: rtl/tb_mem_bus_ctrl.sv
// Two-port memory bus controller: arbitrates fetch and data requests, runs one
// memory access at a time through IDLE/ISSUE/WAIT/DONE and returns read data
// with a one-cycle valid pulse to the owning port.
// Optional watchdog: define MEM_BUS_TIMEOUT_EN to end a WAIT that sees no
// ready within TIMEOUT_CYCLES, raising sticky bus_err and returning 16'hFFFF.
module tb_mem_bus_ctrl
  import pkg_cpu::*;
#(
  parameter int MIN_LAT        = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_we,
  input  logic        d_sz,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req_rdwr,
  output logic [15:0] mem_addr,
  output logic        mem_acc_sz,
  output logic        mem_we_8,
  output logic        mem_we_16,
  output logic [7:0]  mem_wdata_8,
  output logic [15:0] mem_wdata_16,
  input  logic [7:0]  mem_rdata_8,
  input  logic [15:0] mem_rdata_16,
  input  logic        mem_data_ready,
  output logic        busy,
  output logic        bus_err
);

  // Counter is wide enough for whichever limit is larger, plus headroom so
  // the saturated value never aliases below a limit.
  localparam int CNT_LIM = (MIN_LAT > TIMEOUT_CYCLES) ? MIN_LAT : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_LIM + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mem_bus_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  mem_xact_t        xact_q, xact_d;
  logic [15:0]      if_rdata_q, if_rdata_d;
  logic [15:0]      d_rdata_q, d_rdata_d;
  logic [15:0]      rd_sel;
  logic             load;
  mem_port_t        gnt;
  logic             gnt_any;
  mem_port_t        owner;
`ifdef MEM_BUS_TIMEOUT_EN
  logic             bus_err_q, bus_err_d;
`endif

  mem_bus_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .d_req   (d_req),
    .load    (load),
    .gnt     (gnt),
    .gnt_any (gnt_any),
    .owner   (owner)
  );

  // Next-state, transaction latch, wait counter and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xact_d     = xact_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    load       = 1'b0;
    rd_sel     = sel_rdata(xact_q.sz, mem_rdata_8, mem_rdata_16);
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          load        = 1'b1;
          xact_d.port = gnt;
          if (gnt == PORT_D) begin
            xact_d.addr  = d_addr;
            xact_d.we    = d_we;
            xact_d.sz    = d_sz;
            xact_d.wdata = d_wdata;
          end else begin
            xact_d.addr  = if_addr;
            xact_d.we    = 1'b0;
            xact_d.sz    = cpu_data_acc_sz_16;
            xact_d.wdata = 16'h0000;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // Ready is only trusted once MIN_LAT cycles have passed since issue,
        // which also masks a ready left high by the previous access.
        if ((cnt_inc >= CNT_W'(MIN_LAT)) && mem_data_ready) begin
          state_d = DONE;
          if (!xact_q.we) begin
            if (xact_q.port == PORT_D) d_rdata_d  = rd_sel;
            else                       if_rdata_d = rd_sel;
          end
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          if (xact_q.port == PORT_D) d_rdata_d  = 16'hFFFF;
          else                       if_rdata_d = 16'hFFFF;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, transaction and read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      xact_q     <= '0;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xact_q     <= xact_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Outputs decoded from the state register and latched transaction only.
  assign busy         = (state_q != IDLE);
  assign mem_req_rdwr = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_addr     = xact_q.addr;
  assign mem_acc_sz   = xact_q.sz;
  assign mem_wdata_8  = xact_q.wdata[7:0];
  assign mem_wdata_16 = xact_q.wdata;
  assign mem_we_8     = mem_req_rdwr && xact_q.we && (xact_q.sz == cpu_data_acc_sz_8);
  assign mem_we_16    = mem_req_rdwr && xact_q.we && (xact_q.sz == cpu_data_acc_sz_16);
  assign if_valid     = (state_q == DONE) && (owner == PORT_IF);
  assign d_valid      = (state_q == DONE) && (owner == PORT_D);
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_tb_mem_bus_ctrl.sv
// Bench for tb_mem_bus_ctrl: a byte-array memory responder with programmable
// ready latency, and a transaction-level reference model that predicts
// completion cycle, returned data and write-enable activity per access.
module tb_tb_mem_bus_ctrl;
  import pkg_cpu::*;

  localparam int MIN_LAT        = 2;
  localparam int TIMEOUT_CYCLES = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic        d_sz = 1'b0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        mem_req_rdwr;
  logic [15:0] mem_addr;
  logic        mem_acc_sz;
  logic        mem_we_8, mem_we_16;
  logic [7:0]  mem_wdata_8;
  logic [15:0] mem_wdata_16;
  logic [7:0]  mem_rdata_8 = '0;
  logic [15:0] mem_rdata_16 = '0;
  logic        mem_data_ready = 1'b0;
  logic        busy;
  logic        bus_err;

  tb_mem_bus_ctrl #(.MIN_LAT(MIN_LAT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_sz(d_sz), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req_rdwr(mem_req_rdwr), .mem_addr(mem_addr), .mem_acc_sz(mem_acc_sz),
    .mem_we_8(mem_we_8), .mem_we_16(mem_we_16),
    .mem_wdata_8(mem_wdata_8), .mem_wdata_16(mem_wdata_16),
    .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16),
    .mem_data_ready(mem_data_ready), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Memory responder state and reference model state.
  logic [7:0]  bmem [0:65535];
  logic [7:0]  refm [0:65535];
  int          lat_cfg = 1;
  bit          stale_rdy = 1'b0;
  int          req_cyc = 0;
  int          we8_cnt = 0, we16_cnt = 0, req_cnt = 0;
  logic [15:0] exp_if_rdata = 16'h0000;
  logic [15:0] exp_d_rdata  = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ready L cycles after the issue cycle, held until the
  // request drops. Byte at addr sits in the high half of a 16-bit read.
  always @(negedge clk) begin
    if (mem_req_rdwr) req_cyc = req_cyc + 1;
    else              req_cyc = 0;
    mem_data_ready = stale_rdy || (mem_req_rdwr && (req_cyc >= lat_cfg + 1));
    mem_rdata_8    = bmem[mem_addr];
    mem_rdata_16   = {bmem[mem_addr], bmem[mem_addr + 16'd1]};
    if (mem_req_rdwr) req_cnt = req_cnt + 1;
    if (mem_we_8)     we8_cnt = we8_cnt + 1;
    if (mem_we_16)    we16_cnt = we16_cnt + 1;
  end

  // Memory responder write port.
  always @(posedge clk) begin
    if (mem_data_ready && mem_we_16) begin
      bmem[mem_addr]         <= mem_wdata_16[15:8];
      bmem[mem_addr + 16'd1] <= mem_wdata_16[7:0];
    end else if (mem_data_ready && mem_we_8) begin
      bmem[mem_addr] <= mem_wdata_8;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, mem_req_rdwr, 0);
    chk({tag, "_we"}, {mem_we_8, mem_we_16}, 0);
    chk({tag, "_valid"}, {if_valid, d_valid}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata_16, 0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 0);
    chk({tag, "_err"}, bus_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_if_rdata = 16'h0000;
    exp_d_rdata  = 16'h0000;
  endtask

  // One complete transaction on one port, checked against the model.
  task automatic run_xact(input bit is_d, input logic [15:0] a, input bit we,
                          input bit sz, input logic [15:0] wd, input int lat);
    int t0, m, t_got;
    bit seen;
    logic [15:0] a1;
    a1 = a + 16'd1;
    @(negedge clk);
    lat_cfg = lat; we8_cnt = 0; we16_cnt = 0; req_cnt = 0;
    if (is_d) begin
      d_req = 1'b1; d_addr = a; d_we = we; d_sz = sz; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a; we = 1'b0; sz = cpu_data_acc_sz_16;
    end
    t0 = cyc;
    m = stale_rdy ? MIN_LAT : ((lat > MIN_LAT) ? lat : MIN_LAT);
    if (we) begin
      if (sz == cpu_data_acc_sz_16) begin refm[a] = wd[15:8]; refm[a1] = wd[7:0]; end
      else refm[a] = wd[7:0];
    end else begin
      if (is_d) exp_d_rdata  = (sz == cpu_data_acc_sz_16) ? {refm[a], refm[a1]} : {8'h00, refm[a]};
      else      exp_if_rdata = {refm[a], refm[a1]};
    end
    seen = 1'b0; t_got = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (is_d ? d_valid : if_valid) begin seen = 1'b1; t_got = cyc - t0; end
      else if (if_valid || d_valid) chk("stray_valid", {if_valid, d_valid}, 0);
    end
    chk("completed", seen, 1);
    if (seen) begin
      chk("latency", t_got, 2 + m);
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("mem_addr", mem_addr, a);
      chk("req_cycles", req_cnt, m + 1);
      chk("we8_cycles", we8_cnt, (we && sz == cpu_data_acc_sz_8) ? m + 1 : 0);
      chk("we16_cycles", we16_cnt, (we && sz == cpu_data_acc_sz_16) ? m + 1 : 0);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", {if_valid, d_valid}, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int t0, t_d, t_if, n_d, n_if;
    logic [15:0] ra, rd;
    for (int i = 0; i < 65536; i++) begin
      rd = 16'($urandom);
      bmem[i] = rd[7:0];
      refm[i] = rd[7:0];
    end
    bmem[4] = 8'h12; refm[4] = 8'h12;
    bmem[5] = 8'h34; refm[5] = 8'h34;
    bmem[16'h7FFC] = 8'hAB; refm[16'h7FFC] = 8'hAB;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    do_reset();

    // Directed accesses.
    run_xact(1'b0, 16'h0004, 1'b0, cpu_data_acc_sz_16, 16'h0000, 2);
    chk("fetch_1234", if_rdata, 16'h1234);
    run_xact(1'b1, 16'h7FFC, 1'b0, cpu_data_acc_sz_8, 16'h0000, 2);
    chk("byte_00AB", d_rdata, 16'h00AB);
    run_xact(1'b1, 16'h0100, 1'b1, cpu_data_acc_sz_16, 16'hBEEF, 3);
    chk("write_keeps_rdata", d_rdata, 16'h00AB);
    run_xact(1'b1, 16'h0100, 1'b0, cpu_data_acc_sz_16, 16'h0000, 0);
    chk("readback_BEEF", d_rdata, 16'hBEEF);
    run_xact(1'b1, 16'h0101, 1'b1, cpu_data_acc_sz_8, 16'h5A77, 1);
    run_xact(1'b1, 16'h0100, 1'b0, cpu_data_acc_sz_16, 16'h0000, 4);
    chk("byte_write_lane", d_rdata, 16'hBE77);

    // Stale ready held high the whole time: completion still waits MIN_LAT.
    stale_rdy = 1'b1;
    run_xact(1'b1, 16'h0004, 1'b0, cpu_data_acc_sz_16, 16'h0000, 0);
    run_xact(1'b0, 16'h7FFC, 1'b0, cpu_data_acc_sz_16, 16'h0000, 0);
    stale_rdy = 1'b0;

    // Simultaneous requests: data first, fetch re-arbitrated after DONE.
    @(negedge clk);
    lat_cfg = 1;
    d_req = 1'b1; d_addr = 16'h0004; d_we = 1'b0; d_sz = cpu_data_acc_sz_8; d_wdata = 16'h0;
    if_req = 1'b1; if_addr = 16'h0100;
    exp_d_rdata = {8'h00, refm[16'h0004]};
    exp_if_rdata = {refm[16'h0100], refm[16'h0101]};
    t0 = cyc; t_d = -1; t_if = -1; n_d = 0; n_if = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_valid)  begin n_d++;  if (t_d < 0)  t_d = cyc - t0;  d_req = 1'b0;  end
      if (if_valid) begin n_if++; if (t_if < 0) t_if = cyc - t0; if_req = 1'b0; end
    end
    chk("both_d_time", t_d, 2 + MIN_LAT);
    chk("both_if_time", t_if, 2 * (2 + MIN_LAT) + 1);
    chk("both_d_pulses", n_d, 1);
    chk("both_if_pulses", n_if, 1);
    chk("both_d_rdata", d_rdata, exp_d_rdata);
    chk("both_if_rdata", if_rdata, exp_if_rdata);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rd = 16'($urandom);
      run_xact(1'($urandom), ra, 1'($urandom), 1'($urandom), rd, int'($urandom_range(0, 5)));
    end

    // Reset in WAIT abandons the access.
    @(negedge clk);
    lat_cfg = 20;
    d_req = 1'b1; d_addr = 16'h0200; d_we = 1'b0; d_sz = cpu_data_acc_sz_16;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0; d_req = 1'b0;
    exp_d_rdata = 16'h0000; exp_if_rdata = 16'h0000;
    n_d = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_valid || d_valid || busy) n_d++;
    end
    chk("no_valid_after_reset", n_d, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    // Memory never ready: watchdog ends WAIT after TIMEOUT_CYCLES.
    @(negedge clk);
    lat_cfg = 100000;
    d_req = 1'b1; d_addr = 16'h0300; d_we = 1'b0; d_sz = cpu_data_acc_sz_16;
    t0 = cyc; t_d = -1;
    for (int i = 0; i < 40 && t_d < 0; i++) begin
      @(negedge clk);
      if (d_valid) t_d = cyc - t0;
    end
    chk("timeout_time", t_d, 2 + TIMEOUT_CYCLES);
    chk("timeout_rdata", d_rdata, 16'hFFFF);
    chk("timeout_err", bus_err, 1);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", bus_err, 1);
    do_reset();
    chk("err_cleared", bus_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
